// File: rtl/edge_map_binarizer_if.sv
// Pixel stream bundle for the edge map binarizer: filtered pixels in,
// edge bits with frame markers out.
interface edge_map_binarizer_if #(
  parameter int W = 8
);
  logic         x_valid;
  logic         x_ready;
  logic [W-1:0] x_data;
  logic         y_valid;
  logic         y_ready;
  logic         y_data;
  logic         y_sof;
  logic         y_eol;

  modport slave (
    input  x_valid, x_data, y_ready,
    output x_ready, y_valid, y_data, y_sof, y_eol
  );

  modport master (
    output x_valid, x_data, y_ready,
    input  x_ready, y_valid, y_data, y_sof, y_eol
  );
endinterface

// File: rtl/edge_map_binarizer.sv
// Thresholds filtered pixels into a 1-bit edge map behind a ready/valid
// register stage and reports per-frame edge totals and the busiest row.
module edge_map_binarizer #(
  parameter  int IMG_WIDTH  = 640,
  parameter  int IMG_HEIGHT = 480,
  parameter  int W          = 8,
  localparam int CNT_W      = $clog2(IMG_WIDTH*IMG_HEIGHT+1),
  localparam int ROW_W      = $clog2(IMG_WIDTH+1),
  localparam int IDX_W      = $clog2(IMG_HEIGHT)
) (
  input  logic                     clk,
  input  logic                     rst,
  edge_map_binarizer_if.slave      bus,
  input  logic [W-1:0]             threshold,
  output logic                     stat_valid,
  output logic [CNT_W-1:0]         stat_edge_count,
  output logic [ROW_W-1:0]         stat_max_row_count,
  output logic [IDX_W-1:0]         stat_max_row_idx
);
  localparam int X_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [X_W-1:0]   X_LAST = X_W'(IMG_WIDTH-1);
  localparam logic [IDX_W-1:0] Y_LAST = IDX_W'(IMG_HEIGHT-1);

  logic [X_W-1:0]   x_pos_q, x_pos_d;
  logic [IDX_W-1:0] y_pos_q, y_pos_d;
  logic [W-1:0]     thr_q, thr_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [ROW_W-1:0] best_cnt_q, best_cnt_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             y_valid_q, y_valid_d;
  logic             y_data_q, y_data_d;
  logic             y_sof_q, y_sof_d;
  logic             y_eol_q, y_eol_d;
  logic             stat_valid_q, stat_valid_d;
  logic [CNT_W-1:0] stat_cnt_q, stat_cnt_d;
  logic [ROW_W-1:0] stat_max_q, stat_max_d;
  logic [IDX_W-1:0] stat_idx_q, stat_idx_d;

  logic             x_ready;
  logic             accept;
  logic             first_px;
  logic             row_last;
  logic             frame_last;
  logic [W-1:0]     thr_eff;
  logic             edge_bit;
  logic [ROW_W-1:0] row_final;
  logic [CNT_W-1:0] frame_final;
  logic             best_take;
  logic [ROW_W-1:0] best_cnt_new;
  logic [IDX_W-1:0] best_idx_new;

  assign x_ready     = bus.y_ready | ~y_valid_q;
  assign accept      = bus.x_valid & x_ready;
  assign first_px    = (x_pos_q == '0) && (y_pos_q == '0);
  assign row_last    = (x_pos_q == X_LAST);
  assign frame_last  = row_last && (y_pos_q == Y_LAST);

  // The first pixel of a frame uses the live threshold; the rest use the latched copy.
  assign thr_eff     = first_px ? threshold : thr_q;
  assign edge_bit    = (bus.x_data >= thr_eff);
  assign row_final   = row_cnt_q + ROW_W'(edge_bit);
  assign frame_final = frame_cnt_q + CNT_W'(edge_bit);

  // Row 0 always seeds the best; later rows need a strict win so ties keep the earlier row.
  assign best_take    = (y_pos_q == '0) || (row_final > best_cnt_q);
  assign best_cnt_new = best_take ? row_final : best_cnt_q;
  assign best_idx_new = best_take ? y_pos_q : best_idx_q;

  always_comb begin
    x_pos_d      = x_pos_q;
    y_pos_d      = y_pos_q;
    thr_d        = thr_q;
    row_cnt_d    = row_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    best_cnt_d   = best_cnt_q;
    best_idx_d   = best_idx_q;
    y_valid_d    = y_valid_q;
    y_data_d     = y_data_q;
    y_sof_d      = y_sof_q;
    y_eol_d      = y_eol_q;
    stat_valid_d = 1'b0;
    stat_cnt_d   = stat_cnt_q;
    stat_max_d   = stat_max_q;
    stat_idx_d   = stat_idx_q;

    if (accept) begin
      y_valid_d   = 1'b1;
      y_data_d    = edge_bit;
      y_sof_d     = first_px;
      y_eol_d     = row_last;
      frame_cnt_d = frame_final;
      row_cnt_d   = row_final;
      if (first_px) begin
        thr_d = threshold;
      end
      if (row_last) begin
        x_pos_d    = '0;
        y_pos_d    = (y_pos_q == Y_LAST) ? '0 : y_pos_q + IDX_W'(1);
        row_cnt_d  = '0;
        best_cnt_d = best_cnt_new;
        best_idx_d = best_idx_new;
      end else begin
        x_pos_d = x_pos_q + X_W'(1);
      end
      if (frame_last) begin
        stat_valid_d = 1'b1;
        stat_cnt_d   = frame_final;
        stat_max_d   = best_cnt_new;
        stat_idx_d   = best_idx_new;
        frame_cnt_d  = '0;
        best_cnt_d   = '0;
        best_idx_d   = '0;
      end
    end else if (y_valid_q && bus.y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_pos_q      <= '0;
      y_pos_q      <= '0;
      thr_q        <= '0;
      row_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      best_cnt_q   <= '0;
      best_idx_q   <= '0;
      y_valid_q    <= 1'b0;
      y_data_q     <= 1'b0;
      y_sof_q      <= 1'b0;
      y_eol_q      <= 1'b0;
      stat_valid_q <= 1'b0;
      stat_cnt_q   <= '0;
      stat_max_q   <= '0;
      stat_idx_q   <= '0;
    end else begin
      x_pos_q      <= x_pos_d;
      y_pos_q      <= y_pos_d;
      thr_q        <= thr_d;
      row_cnt_q    <= row_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      best_cnt_q   <= best_cnt_d;
      best_idx_q   <= best_idx_d;
      y_valid_q    <= y_valid_d;
      y_data_q     <= y_data_d;
      y_sof_q      <= y_sof_d;
      y_eol_q      <= y_eol_d;
      stat_valid_q <= stat_valid_d;
      stat_cnt_q   <= stat_cnt_d;
      stat_max_q   <= stat_max_d;
      stat_idx_q   <= stat_idx_d;
    end
  end

  assign bus.x_ready         = x_ready;
  assign bus.y_valid         = y_valid_q;
  assign bus.y_data          = y_data_q;
  assign bus.y_sof           = y_sof_q;
  assign bus.y_eol           = y_eol_q;
  assign stat_valid          = stat_valid_q;
  assign stat_edge_count     = stat_cnt_q;
  assign stat_max_row_count  = stat_max_q;
  assign stat_max_row_idx    = stat_idx_q;
endmodule

// File: tb/tb_edge_map_binarizer.sv
// Directed bench for edge_map_binarizer on a 4x3 frame: a vector table of
// four frames plus hand-written backpressure and mid-frame reset sequences.
module tb_edge_map_binarizer;
  localparam int IW    = 4;
  localparam int IH    = 3;
  localparam int NPIX  = IW*IH;
  localparam int CNT_W = $clog2(IW*IH+1);
  localparam int ROW_W = $clog2(IW+1);
  localparam int IDX_W = $clog2(IH);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       threshold = '0;
  logic             stat_valid;
  logic [CNT_W-1:0] stat_edge_count;
  logic [ROW_W-1:0] stat_max_row_count;
  logic [IDX_W-1:0] stat_max_row_idx;

  edge_map_binarizer_if #(.W(8)) bus ();

  edge_map_binarizer #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .W(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus.slave),
    .threshold          (threshold),
    .stat_valid         (stat_valid),
    .stat_edge_count    (stat_edge_count),
    .stat_max_row_count (stat_max_row_count),
    .stat_max_row_idx   (stat_max_row_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]       pix;
    logic [7:0]       thr;
    logic             exp_data;
    logic             exp_sof;
    logic             exp_eol;
    logic             exp_stat;
    logic [CNT_W-1:0] exp_cnt;
    logic [ROW_W-1:0] exp_max;
    logic [IDX_W-1:0] exp_idx;
  } vec_t;

  vec_t tbl [4*NPIX];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int pulse_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log sampled mid-cycle so it sees settled register outputs.
  always @(negedge clk) if (stat_valid) pulse_q.push_back(cyc);

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int i);
    bus.x_valid = 1'b1;
    bus.x_data  = tbl[i].pix;
    threshold   = tbl[i].thr;
    @(posedge clk);
    #1;
    checkOutput($sformatf("y_valid[%0d]", i), 32'(bus.y_valid), 32'd1);
    checkOutput($sformatf("y_data[%0d]", i), 32'(bus.y_data), 32'(tbl[i].exp_data));
    checkOutput($sformatf("y_sof[%0d]", i), 32'(bus.y_sof), 32'(tbl[i].exp_sof));
    checkOutput($sformatf("y_eol[%0d]", i), 32'(bus.y_eol), 32'(tbl[i].exp_eol));
    checkOutput($sformatf("stat_valid[%0d]", i), 32'(stat_valid), 32'(tbl[i].exp_stat));
    if (tbl[i].exp_stat) begin
      checkOutput($sformatf("stat_edge_count[%0d]", i), 32'(stat_edge_count), 32'(tbl[i].exp_cnt));
      checkOutput($sformatf("stat_max_row_count[%0d]", i), 32'(stat_max_row_count), 32'(tbl[i].exp_max));
      checkOutput($sformatf("stat_max_row_idx[%0d]", i), 32'(stat_max_row_idx), 32'(tbl[i].exp_idx));
    end
  endtask

  task automatic idleCycle();
    bus.x_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("drained_y_valid", 32'(bus.y_valid), 32'd0);
    checkOutput("idle_stat_valid", 32'(stat_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] f1 [NPIX] = '{99, 100, 101, 255,  0, 0, 0, 0,  100, 0, 0, 0};
    logic [7:0] f2 [NPIX] = '{128, 127, 0, 0,  255, 129, 5, 130,  200, 200, 200, 127};
    logic [0:NPIX-1] e1 = 12'b0111_0000_1000;
    logic [0:NPIX-1] e2 = 12'b1000_1101_1110;
    logic [0:NPIX-1] e3 = 12'b1111_1111_1111;
    logic [0:NPIX-1] e4 = 12'b0000_0000_0000;
    int n0;

    // Frame 0: basic threshold row; frame 1: 1/3/3 edge rows; frames 2-3: threshold latching.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        int k;
        k = f*NPIX + i;
        tbl[k].exp_sof  = (i == 0);
        tbl[k].exp_eol  = ((i % IW) == IW-1);
        tbl[k].exp_stat = (i == NPIX-1);
        case (f)
          0: begin
            tbl[k].pix = f1[i]; tbl[k].thr = 8'd100; tbl[k].exp_data = e1[i];
            tbl[k].exp_cnt = 4'd4; tbl[k].exp_max = 3'd3; tbl[k].exp_idx = 2'd0;
          end
          1: begin
            tbl[k].pix = f2[i]; tbl[k].thr = 8'd128; tbl[k].exp_data = e2[i];
            tbl[k].exp_cnt = 4'd7; tbl[k].exp_max = 3'd3; tbl[k].exp_idx = 2'd1;
          end
          2: begin
            tbl[k].pix = 8'd100; tbl[k].thr = (i < 2) ? 8'd50 : 8'd200; tbl[k].exp_data = e3[i];
            tbl[k].exp_cnt = 4'd12; tbl[k].exp_max = 3'd4; tbl[k].exp_idx = 2'd0;
          end
          default: begin
            tbl[k].pix = 8'd100; tbl[k].thr = 8'd200; tbl[k].exp_data = e4[i];
            tbl[k].exp_cnt = 4'd0; tbl[k].exp_max = 3'd0; tbl[k].exp_idx = 2'd0;
          end
        endcase
      end
    end

    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    bus.y_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.y_ready = 1'b0;
    #1;
    checkOutput("reset_y_valid", 32'(bus.y_valid), 32'd0);
    checkOutput("reset_y_data", 32'(bus.y_data), 32'd0);
    checkOutput("reset_y_sof", 32'(bus.y_sof), 32'd0);
    checkOutput("reset_y_eol", 32'(bus.y_eol), 32'd0);
    checkOutput("reset_x_ready", 32'(bus.x_ready), 32'd1);
    checkOutput("reset_stat_valid", 32'(stat_valid), 32'd0);
    checkOutput("reset_stat_edge_count", 32'(stat_edge_count), 32'd0);
    checkOutput("reset_stat_max_row_count", 32'(stat_max_row_count), 32'd0);
    checkOutput("reset_stat_max_row_idx", 32'(stat_max_row_idx), 32'd0);
    bus.y_ready = 1'b1;

    $display("[TB] back-to-back frames from the vector table");
    n0 = pulse_q.size();
    for (int i = 0; i < 4*NPIX; i++) applyStimulus(i);
    idleCycle();
    checkOutput("b2b_pulse_count", 32'(pulse_q.size() - n0), 32'd4);
    if (pulse_q.size() >= n0 + 2)
      checkOutput("b2b_pulse_spacing", 32'(pulse_q[n0+1] - pulse_q[n0]), 32'd12);

    $display("[TB] backpressure sequence");
    applyStimulus(NPIX);
    bus.y_ready = 1'b0;
    bus.x_valid = 1'b1;
    bus.x_data  = tbl[NPIX+1].pix;
    threshold   = tbl[NPIX+1].thr;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("stall_x_ready[%0d]", c), 32'(bus.x_ready), 32'd0);
      checkOutput($sformatf("stall_y_valid[%0d]", c), 32'(bus.y_valid), 32'd1);
      checkOutput($sformatf("stall_y_data[%0d]", c), 32'(bus.y_data), 32'd1);
      checkOutput($sformatf("stall_y_sof[%0d]", c), 32'(bus.y_sof), 32'd1);
    end
    bus.y_ready = 1'b1;
    for (int i = NPIX+1; i < 2*NPIX; i++) applyStimulus(i);
    idleCycle();

    $display("[TB] reset mid-frame sequence");
    for (int i = 0; i < 6; i++) applyStimulus(i);
    bus.x_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_y_valid", 32'(bus.y_valid), 32'd0);
    checkOutput("async_reset_y_data", 32'(bus.y_data), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    n0 = pulse_q.size();
    for (int i = NPIX; i < 2*NPIX; i++) applyStimulus(i);
    idleCycle();
    checkOutput("post_reset_pulse_count", 32'(pulse_q.size() - n0), 32'd1);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
